io_mmio_ctrl: RTL

Parametrised memory-mapped I/O controller for the pipelined RISC-V system. It replaces the ad-hoc LED/KEY/SW decode in the board top level. It adds input synchronisation, per-key debouncing with sticky press capture, a key interrupt line, HEX 7-segment drive, byte-masked writes and a loadable cycle counter. It sits beside the data RAM, selected by the top-level `isIO` decode, and its `rdata` feeds the final RAM/I/O read mux.

---
 rtl/io_mmio_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped LED/HEX/KEY/SW/IRQEN/CYCLES block; reads are combinational, writes land on the next edge.
// No backpressure: every access completes in the cycle it is presented.
module io_mmio_ctrl #(
  parameter int N_LEDS          = 10,
  parameter int N_SW            = 10,
  parameter int N_KEYS          = 4,
  parameter int N_HEX           = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wmask,
  output logic [31:0]          rdata,
  input  logic [N_SW-1:0]      sw,
  input  logic [N_KEYS-1:0]    key,
  output logic [N_LEDS-1:0]    ledr,
  output logic [7*N_HEX-1:0]   hex,
  output logic                 irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  logic [N_LEDS-1:0]          ledr_q, ledr_d;
  logic [4*N_HEX-1:0]         dig_q, dig_d;
  logic [N_KEYS-1:0]          irqen_q, irqen_d;
  logic [31:0]                cyc_q, cyc_d;
  logic [N_KEYS-1:0]          key_s1_q, key_s2_q;
  logic [N_SW-1:0]            sw_s1_q, sw_s2_q;
  logic [N_KEYS-1:0]          lvl_q, lvl_d;
  logic [N_KEYS-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N_KEYS-1:0]          cap_q, cap_d;
  logic                       irq_q, irq_d;

  logic [5:0]        a_sel, hit;
  logic              wr;
  logic [31:0]       bmask;
  logic [N_KEYS-1:0] clr;
  logic [31:0]       led_x, dig_x, key_x, sw_x, irqen_x;
  logic              unused_addr;

  assign unused_addr = ^{addr[31:8], addr[1:0]};

  // Isolate the lowest set select bit so overlapping selects resolve to one register.
  assign a_sel = addr[7:2];
  assign hit   = a_sel & (~a_sel + 6'd1);
  assign wr    = sel & we;
  assign bmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

  always_comb begin
    led_x   = '0;
    dig_x   = '0;
    key_x   = '0;
    sw_x    = '0;
    irqen_x = '0;
    led_x[N_LEDS-1:0]   = ledr_q;
    dig_x[4*N_HEX-1:0]  = dig_q;
    key_x[N_KEYS-1:0]   = lvl_q;
    key_x[16 +: N_KEYS] = cap_q;
    sw_x[N_SW-1:0]      = sw_s2_q;
    irqen_x[N_KEYS-1:0] = irqen_q;
  end

  always_comb begin
    ledr_d  = ledr_q;
    dig_d   = dig_q;
    irqen_d = irqen_q;
    clr     = '0;
    if (wr && hit[0]) ledr_d  = N_LEDS'(merge(led_x, wdata, bmask));
    if (wr && hit[1]) dig_d   = (4*N_HEX)'(merge(dig_x, wdata, bmask));
    if (wr && hit[2]) clr     = N_KEYS'((wdata & bmask) >> 16);
    if (wr && hit[4]) irqen_d = N_KEYS'(merge(irqen_x, wdata, bmask));
    cyc_d = (wr && hit[5]) ? merge(cyc_q, wdata, bmask) : cyc_q + 32'd1;

    // Key samples are active-low; the counter must see DEBOUNCE_CYCLES+1 disagreeing samples to flip.
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N_KEYS; i++) begin
      if (~key_s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          lvl_d[i] = ~key_s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end

    cap_d = (cap_q & ~clr) | (lvl_d & ~lvl_q);
    irq_d = |(cap_q & irqen_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ledr_q   <= '0;
      dig_q    <= '0;
      irqen_q  <= '0;
      cyc_q    <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      lvl_q    <= '0;
      cnt_q    <= '0;
      cap_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      ledr_q   <= ledr_d;
      dig_q    <= dig_d;
      irqen_q  <= irqen_d;
      cyc_q    <= cyc_d;
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      if (hit[0])      rdata = led_x;
      else if (hit[1]) rdata = dig_x;
      else if (hit[2]) rdata = key_x;
      else if (hit[3]) rdata = sw_x;
      else if (hit[4]) rdata = irqen_x;
      else if (hit[5]) rdata = cyc_q;
    end
  end

  always_comb begin
    hex = '0;
    for (int d = 0; d < N_HEX; d++) hex[7*d +: 7] = seg7(dig_q[4*d +: 4]);
  end

  assign ledr = ledr_q;
  assign irq  = irq_q;

endmodule
